// File: rtl/drop_door_sequencer_pkg.sv
// Shared definitions for the drop-door sequencer.
// Contents: FSM state encoding (3-bit), default cycle constants and a helper
// used to size the shared phase timer.

package drop_door_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArm      = 3'd1,
        StOpen     = 3'd2,
        StClosing  = 3'd3,
        StCooldown = 3'd4,
        StFault    = 3'd5
    } state_e;

    localparam int unsigned DEF_ARM_CYCLES      = 4;
    localparam int unsigned DEF_OPEN_CYCLES     = 1000;
    localparam int unsigned DEF_CLOSE_TIMEOUT   = 2000;
    localparam int unsigned DEF_COOLDOWN_CYCLES = 500;
    localparam int unsigned DEF_CNT_W           = 16;

    function automatic int unsigned max_of4(int unsigned a, int unsigned b,
                                            int unsigned c, int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/drop_door_sequencer_if.sv
// Bus between the drop-door sequencer and its environment.
// Signals:
//   drop_activated  - drop decision from baggage_drop (may glitch)
//   drop_en         - operator enable
//   door_closed_sns - asynchronous door-closed limit switch, 1 = closed
//   fault_clr       - synchronous fault acknowledge
//   door_open       - actuator command, 1 = open
//   busy            - sequencer not idle
//   fault           - latched close-timeout fault
//   drop_count      - completed drops, saturating
// Modports: master drives the requests/sensor, slave is the sequencer.

interface drop_door_sequencer_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             drop_activated;
    logic             drop_en;
    logic             door_closed_sns;
    logic             fault_clr;
    logic             door_open;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output drop_activated,
        output drop_en,
        output door_closed_sns,
        output fault_clr,
        input  door_open,
        input  busy,
        input  fault,
        input  drop_count
    );

    modport slave (
        input  drop_activated,
        input  drop_en,
        input  door_closed_sns,
        input  fault_clr,
        output door_open,
        output busy,
        output fault,
        output drop_count
    );

endinterface

// File: rtl/drop_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, loads RESET_VAL into both flops
//   i_d - asynchronous input
//   o_q - synchronized output (two cycles of latency)

module drop_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/drop_door_sequencer.sv
// Drop-door sequencer: arms on a sustained drop request, holds the door open
// for a fixed time, supervises closure against the synchronized door-closed
// sensor, latches a close-timeout fault and counts completed drops.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset (closes the door immediately)
//   io_bus - slave side of drop_door_sequencer_if (requests, sensor,
//            fault acknowledge in; door_open/busy/fault/drop_count out)
// All outputs are registered.

module drop_door_sequencer
    import drop_door_sequencer_pkg::*;
#(
    parameter int unsigned ARM_CYCLES      = DEF_ARM_CYCLES,
    parameter int unsigned OPEN_CYCLES     = DEF_OPEN_CYCLES,
    parameter int unsigned CLOSE_TIMEOUT   = DEF_CLOSE_TIMEOUT,
    parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    drop_door_sequencer_if.slave io_bus
);

    localparam int unsigned MAX_CYC = max_of4(ARM_CYCLES, OPEN_CYCLES,
                                              CLOSE_TIMEOUT, COOLDOWN_CYCLES);
    localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] C_ARM  = TMR_W'(ARM_CYCLES);
    localparam logic [TMR_W-1:0] C_OPEN = TMR_W'(OPEN_CYCLES);
    localparam logic [TMR_W-1:0] C_TO   = TMR_W'(CLOSE_TIMEOUT);
    localparam logic [TMR_W-1:0] C_COOL = TMR_W'(COOLDOWN_CYCLES);

    state_e             r_state;
    state_e             w_state_d;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_d;
    logic [TMR_W-1:0]   w_tmr_inc;
    logic               w_count_inc;
    logic               w_q;
    logic               w_sns_s;
    logic               r_door_open;
    logic               r_busy;
    logic               r_fault;
    logic [CNT_W-1:0]   r_drop_count;

    // Sensor resets to "closed" so a reset never looks like a stuck-open door.
    drop_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sns_sync (
        .clk (clk),
        .rst (rst),
        .i_d (io_bus.door_closed_sns),
        .o_q (w_sns_s)
    );

    assign w_q       = io_bus.drop_en & io_bus.drop_activated;
    assign w_tmr_inc = r_timer + TMR_W'(1);

    always_comb begin
        w_state_d   = r_state;
        w_timer_d   = r_timer;
        w_count_inc = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_q) begin
                    if (ARM_CYCLES == 1) begin
                        w_state_d = StOpen;
                        w_timer_d = '0;
                    end else begin
                        w_state_d = StArm;
                        w_timer_d = TMR_W'(1);
                    end
                end
            end
            StArm: begin
                // Any gap in the request restarts arming from scratch.
                if (!w_q) begin
                    w_state_d = StIdle;
                    w_timer_d = '0;
                end else if (w_tmr_inc == C_ARM) begin
                    w_state_d = StOpen;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = w_tmr_inc;
                end
            end
            StOpen: begin
                // Operator abort takes priority over expiry and is not counted.
                if (!io_bus.drop_en) begin
                    w_state_d = StClosing;
                    w_timer_d = '0;
                end else if (w_tmr_inc == C_OPEN) begin
                    w_state_d   = StClosing;
                    w_timer_d   = '0;
                    w_count_inc = 1'b1;
                end else begin
                    w_timer_d = w_tmr_inc;
                end
            end
            StClosing: begin
                // Sensor is checked first so it wins on the timeout edge.
                if (w_sns_s) begin
                    w_state_d = StCooldown;
                    w_timer_d = '0;
                end else if (w_tmr_inc == C_TO) begin
                    w_state_d = StFault;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = w_tmr_inc;
                end
            end
            StCooldown: begin
                if (w_tmr_inc == C_COOL) begin
                    w_state_d = StIdle;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = w_tmr_inc;
                end
            end
            StFault: begin
                if (io_bus.fault_clr && w_sns_s) begin
                    w_state_d = StIdle;
                    w_timer_d = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_timer      <= '0;
            r_door_open  <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state     <= w_state_d;
            r_timer     <= w_timer_d;
            // Outputs follow the next state so they line up with the state register.
            r_door_open <= (w_state_d == StOpen);
            r_busy      <= (w_state_d != StIdle);
            r_fault     <= (w_state_d == StFault);
            if (w_count_inc && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign io_bus.door_open  = r_door_open;
    assign io_bus.busy       = r_busy;
    assign io_bus.fault      = r_fault;
    assign io_bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_drop_door_sequencer.sv
// Self-checking bench for drop_door_sequencer: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural model of the drop cycle.

module tb_drop_door_sequencer;

    localparam int unsigned ARM     = 4;
    localparam int unsigned OPENC   = 8;
    localparam int unsigned TO      = 16;
    localparam int unsigned COOL    = 6;
    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic q_act = 1'b0;
    logic en    = 1'b0;
    logic clr   = 1'b0;
    logic sns_r = 1'b1;
    bit   stuck = 1'b0;
    int   close_lat = 3;
    int   since = 0;
    bit   chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    drop_door_sequencer_if #(.CNT_W(CW)) bus ();

    assign bus.drop_activated  = q_act;
    assign bus.drop_en         = en;
    assign bus.fault_clr       = clr;
    assign bus.door_closed_sns = sns_r;

    drop_door_sequencer #(
        .ARM_CYCLES      (ARM),
        .OPEN_CYCLES     (OPENC),
        .CLOSE_TIMEOUT   (TO),
        .COOLDOWN_CYCLES (COOL),
        .CNT_W           (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    // Behavioural model: counts of consecutive requests, remaining open time,
    // closing age, remaining cooldown, fault flag, drop total, sensor delay line.
    typedef struct {
        int run;
        int open_left;
        int age;
        int cool_left;
        int count;
        bit closing;
        bit fault;
        bit d1;
        bit d2;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.run = 0; m.open_left = 0; m.age = 0; m.cool_left = 0; m.count = 0;
        m.closing = 1'b0; m.fault = 1'b0; m.d1 = 1'b1; m.d2 = 1'b1;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit act, bit e, bit c, bit s);
        mdl_t n;
        bit   seen;
        bit   q;
        n    = m;
        seen = m.d2;
        n.d2 = m.d1;
        n.d1 = s;
        q    = act & e;
        if (m.fault) begin
            if (c && seen) n.fault = 1'b0;
        end else if (m.open_left > 0) begin
            if (!e) begin
                n.open_left = 0; n.closing = 1'b1; n.age = 0;
            end else begin
                n.open_left = m.open_left - 1;
                if (n.open_left == 0) begin
                    n.count   = (m.count < CNT_MAX) ? m.count + 1 : m.count;
                    n.closing = 1'b1;
                    n.age     = 0;
                end
            end
        end else if (m.closing) begin
            if (seen) begin
                n.closing = 1'b0; n.cool_left = COOL;
            end else begin
                n.age = m.age + 1;
                if (n.age == TO) begin
                    n.closing = 1'b0; n.fault = 1'b1;
                end
            end
        end else if (m.cool_left > 0) begin
            n.cool_left = m.cool_left - 1;
        end else if (q) begin
            n.run = m.run + 1;
            if (n.run == ARM) begin
                n.run = 0; n.open_left = OPENC;
            end
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    function automatic bit mdl_busy(mdl_t m);
        return (m.run > 0) || (m.open_left > 0) || m.closing || (m.cool_left > 0) || m.fault;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) mdl <= mdl_reset();
        else     mdl <= mdl_step(mdl, q_act, en, clr, sns_r);
    end

    // Door physics: sensor drops as soon as the door opens, returns close_lat
    // cycles after the door is commanded shut unless the door is stuck.
    always @(negedge clk) begin
        if (mdl.open_left > 0) begin
            sns_r <= 1'b0;
            since <= 0;
        end else if (stuck) begin
            sns_r <= 1'b0;
        end else if (since >= close_lat) begin
            sns_r <= 1'b1;
        end else begin
            since <= since + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && chk_en) begin
            check("cyc_door_open", int'(bus.door_open), int'(mdl.open_left > 0));
            check("cyc_busy", int'(bus.busy), int'(mdl_busy(mdl)));
            check("cyc_fault", int'(bus.fault), int'(mdl.fault));
            check("cyc_drop_count", int'(bus.drop_count), mdl.count);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    bit glitch_pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        #3 rst = 1'b1;
        #1;
        check("rst_door_open", int'(bus.door_open), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_fault", int'(bus.fault), 0);
        check("rst_drop_count", int'(bus.drop_count), 0);
        step(2);
        rst    = 1'b0;
        en     = 1'b1;
        chk_en = 1'b1;
        step(4);

        // Glitch rejection: pulses of 1, 2 and 3 cycles.
        for (int i = 0; i < 9; i++) begin
            q_act = glitch_pat[i];
            step(1);
        end
        step(3);
        check("glitch_busy", int'(bus.busy), 0);
        check("glitch_count", int'(bus.drop_count), 0);

        // Nominal drop.
        close_lat = 3;
        q_act = 1'b1;
        step(3);
        check("nom_door_before_4th", int'(bus.door_open), 0);
        step(1);
        check("nom_door_at_4th", int'(bus.door_open), 1);
        step(7);
        check("nom_door_last_open", int'(bus.door_open), 1);
        q_act = 1'b0;
        step(1);
        check("nom_door_closed", int'(bus.door_open), 0);
        check("nom_count", int'(bus.drop_count), 1);
        step(20);
        check("nom_idle_after_cool", int'(bus.busy), 0);

        // Abort on the 3rd open cycle.
        q_act = 1'b1;
        step(4);
        check("abort_door_open", int'(bus.door_open), 1);
        step(2);
        en = 1'b0;
        q_act = 1'b0;
        step(1);
        check("abort_door_fall", int'(bus.door_open), 0);
        check("abort_count", int'(bus.drop_count), 1);
        en = 1'b1;
        step(25);
        check("abort_idle", int'(bus.busy), 0);

        // Close timeout, ignored ack while open, then clean ack.
        q_act = 1'b1;
        step(4);
        stuck = 1'b1;
        q_act = 1'b0;
        step(8);
        check("to_door_closed", int'(bus.door_open), 0);
        step(15);
        check("to_no_fault_yet", int'(bus.fault), 0);
        step(1);
        check("to_fault_set", int'(bus.fault), 1);
        clr = 1'b1;
        step(5);
        check("to_clr_ignored", int'(bus.fault), 1);
        stuck = 1'b0;
        step(10);
        check("to_clr_done", int'(bus.fault), 0);
        check("to_idle", int'(bus.busy), 0);
        check("to_count", int'(bus.drop_count), 2);
        clr = 1'b0;

        // Saturation: back-to-back drops with the request held.
        @(negedge clk) rst = 1'b1;
        step(1);
        rst = 1'b0;
        close_lat = 2;
        q_act = 1'b1;
        step(420);
        check("sat_count", int'(bus.drop_count), 15);

        // Async reset in the middle of OPEN.
        q_act = 1'b0;
        step(40);
        q_act = 1'b1;
        step(ARM + 3);
        check("mid_open_door", int'(bus.door_open), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_door_open", int'(bus.door_open), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_count", int'(bus.drop_count), 0);
        q_act = 1'b0;
        step(2);
        rst = 1'b0;
        step(5);
        check("arst_stays_idle", int'(bus.busy), 0);
        q_act = 1'b1;
        step(ARM);
        check("arst_fresh_drop", int'(bus.door_open), 1);
        q_act = 1'b0;
        step(30);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) q_act = ~q_act;
            en  = ($urandom_range(49) != 0);
            clr = ($urandom_range(9) == 0);
            if ($urandom_range(199) == 0) stuck = ~stuck;
            if ((i % 32) == 0) close_lat = $urandom_range(5);
            step(1);
        end
        stuck = 1'b0;
        q_act = 1'b0;
        en    = 1'b1;
        clr   = 1'b1;
        step(60);
        check("end_idle", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
